// File: rtl/cgra_ctrl_pkg.sv
// Shared types and defaults for the CGRA execution sequencer.
// Pulled into the sequencer and the end-flag collector with a wildcard import.
package cgra_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } exec_state_e;

    typedef enum logic {
        ANY = 1'b0,
        ALL = 1'b1
    } done_mode_e;

    localparam int unsigned DEFAULT_TIMEOUT = 2**20;

endpackage

// File: rtl/cgra_end_collector.sv
// Accumulates per-tile end flags during RUN and reports any-tile and all-masked-tile hits.
// The hits include this cycle's flags, so completion is seen in the same cycle they arrive.
module cgra_end_collector
    import cgra_ctrl_pkg::*;
#(
    parameter int NB_TILES = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Clear_I,
    input  logic                Enable_I,
    input  logic [NB_TILES-1:0] Mask_I,
    input  logic [NB_TILES-1:0] End_Exec_I,
    output logic                Hit_Any_O,
    output logic                Hit_All_O
);

    logic [NB_TILES-1:0] sticky_q;
    logic [NB_TILES-1:0] masked_end;

    assign masked_end = End_Exec_I & Mask_I;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sticky_q <= '0;
        end else if (Clear_I) begin
            sticky_q <= '0;
        end else if (Enable_I) begin
            sticky_q <= sticky_q | masked_end;
        end
    end

    assign Hit_Any_O = |masked_end;
    assign Hit_All_O = ((sticky_q | End_Exec_I) & Mask_I) == Mask_I;

endmodule

// File: rtl/cgra_exec_ctrl.sv
// Execution sequencer above cgratop: drives Initn/Context_Fetch_En, decides completion,
// counts RUN cycles, enforces a watchdog and raises sticky done/error interrupts.
module cgra_exec_ctrl
    import cgra_ctrl_pkg::*;
#(
    parameter int          NB_ROWS     = 4,
    parameter int          NB_COLS     = 4,
    parameter int          INIT_CYCLES = 4,
    parameter int          CNT_WIDTH   = 32,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Start_I,
    input  logic                       Mode_I,
    input  logic [NB_ROWS*NB_COLS-1:0] Tile_Mask_I,
    input  logic [NB_ROWS*NB_COLS-1:0] End_Exec_I,
    input  logic                       Irq_Clr_I,
    output logic                       Initn_O,
    output logic                       Context_Fetch_En_O,
    output logic                       Busy_O,
    output logic                       Done_O,
    output logic                       Error_O,
    output logic                       Irq_O,
    output logic [CNT_WIDTH-1:0]       Exec_Cycles_O
);

    localparam int                   NB_TILES  = NB_ROWS * NB_COLS;
    localparam int                   IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

    exec_state_e          state_q;
    done_mode_e           mode_q;
    logic [NB_TILES-1:0]  mask_q;
    logic [IW-1:0]        init_cnt_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 initn_q, cfe_q, busy_q, done_q, error_q, irq_q;

    logic start_ok;
    logic hit_any, hit_all, complete;

    assign start_ok = (state_q == IDLE) && Start_I && (|Tile_Mask_I);
    assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign complete = (mode_q == ALL) ? hit_all : hit_any;

    cgra_end_collector #(
        .NB_TILES (NB_TILES)
    ) u_end_collector (
        .Clk        (Clk),
        .Reset      (Reset),
        .Clear_I    (start_ok),
        .Enable_I   (state_q == RUN),
        .Mask_I     (mask_q),
        .End_Exec_I (End_Exec_I),
        .Hit_Any_O  (hit_any),
        .Hit_All_O  (hit_all)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            mode_q     <= ANY;
            mask_q     <= '0;
            init_cnt_q <= '0;
            cnt_q      <= '0;
            initn_q    <= 1'b0;
            cfe_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // NOTE: the set branches below are later non-blocking writes, so they override this clear.
            if (Irq_Clr_I) begin
                irq_q   <= 1'b0;
                error_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q    <= INIT;
                        mode_q     <= done_mode_e'(Mode_I);
                        mask_q     <= Tile_Mask_I;
                        init_cnt_q <= IW'(INIT_CYCLES - 1);
                        cnt_q      <= '0;
                        initn_q    <= 1'b0;
                        cfe_q      <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (Start_I) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                        irq_q   <= 1'b1;
                    end
                end
                INIT: begin
                    if (init_cnt_q == '0) begin
                        state_q <= RUN;
                        initn_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q - IW'(1);
                    end
                end
                RUN: begin
                    cnt_q <= cnt_d;
                    if (complete) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        irq_q   <= 1'b1;
                        cfe_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_d == TIMEOUT_C) begin
                        state_q <= ERR;
                        error_q <= 1'b1;
                        irq_q   <= 1'b1;
                        cfe_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                DONE, ERR: state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    assign Initn_O            = initn_q;
    assign Context_Fetch_En_O = cfe_q;
    assign Busy_O             = busy_q;
    assign Done_O             = done_q;
    assign Error_O            = error_q;
    assign Irq_O              = irq_q;
    assign Exec_Cycles_O      = cnt_q;

endmodule

// File: tb/tb_cgra_exec_ctrl.sv
// Directed bench for cgra_exec_ctrl: ANY/ALL completion, watchdog, empty mask,
// mid-run reset, ignored start and irq set/clear collision.
module tb_cgra_exec_ctrl;
    import cgra_ctrl_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start_I, Mode_I, Irq_Clr_I;
    logic [15:0] Tile_Mask_I, End_Exec_I;
    logic        Initn_O, Context_Fetch_En_O, Busy_O, Done_O, Error_O, Irq_O;
    logic [31:0] Exec_Cycles_O;
    logic        initn_before;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    cgra_exec_ctrl #(
        .NB_ROWS     (4),
        .NB_COLS     (4),
        .INIT_CYCLES (4),
        .CNT_WIDTH   (32),
        .TIMEOUT     (20)
    ) dut (
        .Clk                (Clk),
        .Reset              (Reset),
        .Start_I            (Start_I),
        .Mode_I             (Mode_I),
        .Tile_Mask_I        (Tile_Mask_I),
        .End_Exec_I         (End_Exec_I),
        .Irq_Clr_I          (Irq_Clr_I),
        .Initn_O            (Initn_O),
        .Context_Fetch_En_O (Context_Fetch_En_O),
        .Busy_O             (Busy_O),
        .Done_O             (Done_O),
        .Error_O            (Error_O),
        .Irq_O              (Irq_O),
        .Exec_Cycles_O      (Exec_Cycles_O)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic mode, input logic [15:0] mask);
        Start_I     = 1'b1;
        Mode_I      = mode;
        Tile_Mask_I = mask;
        step();
        Start_I     = 1'b0;
    endtask

    // Called right after the start edge; leaves the bench in RUN cycle 0.
    task automatic init_phase(input string tag);
        for (int i = 0; i < 4; i++) begin
            check({tag, " initn_low"}, 32'(Initn_O), 32'd0);
            check({tag, " cfe_init"}, 32'(Context_Fetch_En_O), 32'd1);
            check({tag, " busy_init"}, 32'(Busy_O), 32'd1);
            step();
        end
        check({tag, " initn_high"}, 32'(Initn_O), 32'd1);
        check({tag, " cnt_run0"}, Exec_Cycles_O, 32'd0);
    endtask

    task automatic clear_irq(input string tag);
        Irq_Clr_I = 1'b1;
        step();
        Irq_Clr_I = 1'b0;
        check({tag, " irq_clr"}, 32'(Irq_O), 32'd0);
        check({tag, " err_clr"}, 32'(Error_O), 32'd0);
    endtask

    initial begin
        Reset = 1'b0; Start_I = 1'b0; Mode_I = 1'b0; Irq_Clr_I = 1'b0;
        Tile_Mask_I = '0; End_Exec_I = '0;
        #2;
        check("rst initn", 32'(Initn_O), 32'd0);
        check("rst cfe", 32'(Context_Fetch_En_O), 32'd0);
        check("rst busy", 32'(Busy_O), 32'd0);
        check("rst done", 32'(Done_O), 32'd0);
        check("rst error", 32'(Error_O), 32'd0);
        check("rst irq", 32'(Irq_O), 32'd0);
        check("rst cnt", Exec_Cycles_O, 32'd0);
        step(); step();
        Reset = 1'b1;
        step();

        // ANY mode, tile 5 ends in RUN cycle 10
        start_run(1'b0, 16'hFFFF);
        init_phase("t1");
        for (int r = 0; r < 10; r++) begin
            check("t1 no_done", 32'(Done_O), 32'd0);
            step();
        end
        check("t1 cnt10", Exec_Cycles_O, 32'd10);
        End_Exec_I = 16'h0020;
        step();
        End_Exec_I = '0;
        check("t1 done", 32'(Done_O), 32'd1);
        check("t1 irq", 32'(Irq_O), 32'd1);
        check("t1 cfe_off", 32'(Context_Fetch_En_O), 32'd0);
        check("t1 busy_off", 32'(Busy_O), 32'd0);
        check("t1 initn_hold", 32'(Initn_O), 32'd1);
        check("t1 cnt", Exec_Cycles_O, 32'd11);
        step();
        check("t1 done_pulse", 32'(Done_O), 32'd0);
        check("t1 irq_sticky", 32'(Irq_O), 32'd1);
        check("t1 cnt_hold", Exec_Cycles_O, 32'd11);
        clear_irq("t1");

        // ALL mode, flags held during INIT must be ignored
        End_Exec_I = 16'h000F;
        start_run(1'b1, 16'h000F);
        init_phase("t2");
        End_Exec_I = '0;
        for (int r = 0; r < 10; r++) begin
            case (r)
                1:       End_Exec_I = 16'h1000;
                2:       End_Exec_I = 16'h0001;
                5:       End_Exec_I = 16'h0002;
                7:       End_Exec_I = 16'h0004;
                9:       End_Exec_I = 16'h0008;
                default: End_Exec_I = 16'h0000;
            endcase
            step();
            End_Exec_I = '0;
            if (r < 9) check("t2 no_done", 32'(Done_O), 32'd0);
        end
        check("t2 done", 32'(Done_O), 32'd1);
        check("t2 cnt", Exec_Cycles_O, 32'd10);
        step();
        clear_irq("t2");

        // Watchdog: no end flags, TIMEOUT = 20
        start_run(1'b0, 16'hFFFF);
        init_phase("t3");
        for (int r = 0; r < 19; r++) step();
        check("t3 err_before", 32'(Error_O), 32'd0);
        check("t3 cnt19", Exec_Cycles_O, 32'd19);
        step();
        check("t3 error", 32'(Error_O), 32'd1);
        check("t3 irq", 32'(Irq_O), 32'd1);
        check("t3 cfe_off", 32'(Context_Fetch_En_O), 32'd0);
        check("t3 no_done", 32'(Done_O), 32'd0);
        check("t3 busy_off", 32'(Busy_O), 32'd0);
        check("t3 cnt20", Exec_Cycles_O, 32'd20);
        step();
        check("t3 err_sticky", 32'(Error_O), 32'd1);
        clear_irq("t3");

        // Completion in the timeout cycle wins
        start_run(1'b0, 16'hFFFF);
        init_phase("t3b");
        for (int r = 0; r < 19; r++) step();
        End_Exec_I = 16'h8000;
        step();
        End_Exec_I = '0;
        check("t3b done", 32'(Done_O), 32'd1);
        check("t3b no_error", 32'(Error_O), 32'd0);
        check("t3b cnt", Exec_Cycles_O, 32'd20);
        step();
        clear_irq("t3b");

        // Empty mask goes straight to ERR without touching Initn
        initn_before = Initn_O;
        start_run(1'b0, 16'h0000);
        check("t4 error", 32'(Error_O), 32'd1);
        check("t4 irq", 32'(Irq_O), 32'd1);
        check("t4 busy", 32'(Busy_O), 32'd0);
        check("t4 cfe", 32'(Context_Fetch_En_O), 32'd0);
        check("t4 initn", 32'(Initn_O), 32'(initn_before));
        step();
        check("t4 err_sticky", 32'(Error_O), 32'd1);
        check("t4 initn_idle", 32'(Initn_O), 32'(initn_before));
        clear_irq("t4");

        // Reset in RUN cycle 3, then a clean second run
        start_run(1'b1, 16'h0003);
        init_phase("t5a");
        End_Exec_I = 16'h0001;
        step();
        End_Exec_I = '0;
        step(); step();
        check("t5 cnt3", Exec_Cycles_O, 32'd3);
        Reset = 1'b0;
        #1;
        check("t5 rst initn", 32'(Initn_O), 32'd0);
        check("t5 rst cfe", 32'(Context_Fetch_En_O), 32'd0);
        check("t5 rst busy", 32'(Busy_O), 32'd0);
        check("t5 rst done", 32'(Done_O), 32'd0);
        check("t5 rst error", 32'(Error_O), 32'd0);
        check("t5 rst irq", 32'(Irq_O), 32'd0);
        check("t5 rst cnt", Exec_Cycles_O, 32'd0);
        step();
        Reset = 1'b1;
        step();
        start_run(1'b1, 16'h0003);
        init_phase("t5b");
        End_Exec_I = 16'h0002;
        step();
        End_Exec_I = '0;
        check("t5 no_done", 32'(Done_O), 32'd0);
        step();
        End_Exec_I = 16'h0001;
        step();
        End_Exec_I = '0;
        check("t5 done", 32'(Done_O), 32'd1);
        check("t5 cnt", Exec_Cycles_O, 32'd3);
        step();
        clear_irq("t5");

        // Start during RUN ignored; Irq_Clr with completion keeps Irq set
        start_run(1'b0, 16'h0100);
        init_phase("t6");
        step();
        Start_I = 1'b1; Tile_Mask_I = 16'hFFFF;
        step();
        Start_I = 1'b0;
        check("t6 busy_run", 32'(Busy_O), 32'd1);
        check("t6 initn_run", 32'(Initn_O), 32'd1);
        check("t6 cfe_run", 32'(Context_Fetch_En_O), 32'd1);
        check("t6 cnt2", Exec_Cycles_O, 32'd2);
        step();
        End_Exec_I = 16'h0100;
        Irq_Clr_I  = 1'b1;
        step();
        End_Exec_I = '0;
        Irq_Clr_I  = 1'b0;
        check("t6 done", 32'(Done_O), 32'd1);
        check("t6 irq_set_wins", 32'(Irq_O), 32'd1);
        check("t6 cnt", Exec_Cycles_O, 32'd4);
        Start_I = 1'b1;
        step();
        Start_I = 1'b0;
        check("t6 start_in_done", 32'(Busy_O), 32'd0);
        check("t6 initn_idle", 32'(Initn_O), 32'd1);
        check("t6 irq_hold", 32'(Irq_O), 32'd1);
        step();
        check("t6 no_queue", 32'(Busy_O), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
